// File: rtl/pipeline_controller.sv
// pipeline_controller: control unit for the 5-stage F/D/E/M/W MIPS-subset core.
// Decodes the instruction in D and carries its control through D/E, E/M and M/W.
// It drives the forwarding selects and detects load-use and branch/jump hazards.
// Saturating stall/flush counters are provided for debug visibility.
module pipeline_controller #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode_d,
  input  logic [5:0]        funct_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              zero_e,
  output logic              jump_d,
  output logic              pcsrc_e,
  output logic              alusrc_e,
  output logic [2:0]        alucontrol_e,
  output logic              memwrite_m,
  output logic              regwrite_w,
  output logic              memtoreg_w,
  output logic [REG_AW-1:0] writereg_w,
  output logic              regdst_e,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              illegal_d,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_t;

  typedef struct packed {
    ctrl_t             c;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wr;
  } de_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic [REG_AW-1:0] wr;
  } em_t;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [REG_AW-1:0] wr;
  } mw_t;

  ctrl_t             ctrl_dec;
  logic              jump_dec;
  logic              ill_dec;
  logic [REG_AW-1:0] wr_dec;
  logic              haz;

  de_t de_q, de_d;
  em_t em_q, em_d;
  mw_t mw_q, mw_d;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // writer w collides with one of the two sources; $0 never collides
  function automatic logic hit(input logic [REG_AW-1:0] w,
                               input logic [REG_AW-1:0] a,
                               input logic [REG_AW-1:0] b);
    return (w != '0) && ((w == a) || (w == b));
  endfunction

  // M (ALU result) wins over W when both write the same source
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input em_t m, input mw_t w);
    if (!FWD_EN)                                            return 2'b00;
    else if (m.regwrite && (src != '0) && (m.wr == src))    return 2'b10;
    else if (w.regwrite && (src != '0) && (w.wr == src))    return 2'b01;
    else                                                    return 2'b00;
  endfunction

  // decode the instruction in D; unsupported encodings collapse to a bubble
  always_comb begin
    ctrl_dec = '0;
    jump_dec = 1'b0;
    ill_dec  = 1'b0;
    case (opcode_d)
      OP_RTYPE: begin
        ctrl_dec.regwrite = 1'b1;
        ctrl_dec.regdst   = 1'b1;
        case (funct_d)
          FN_ADD:  ctrl_dec.alucontrol = ALU_ADD;
          FN_SUB:  ctrl_dec.alucontrol = ALU_SUB;
          FN_AND:  ctrl_dec.alucontrol = ALU_AND;
          FN_OR:   ctrl_dec.alucontrol = ALU_OR;
          FN_SLT:  ctrl_dec.alucontrol = ALU_SLT;
          default: ill_dec = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl_dec.regwrite   = 1'b1;
        ctrl_dec.memtoreg   = 1'b1;
        ctrl_dec.alusrc     = 1'b1;
        ctrl_dec.alucontrol = ALU_ADD;
      end
      OP_SW: begin
        ctrl_dec.memwrite   = 1'b1;
        ctrl_dec.alusrc     = 1'b1;
        ctrl_dec.alucontrol = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_dec.branch     = 1'b1;
        ctrl_dec.alucontrol = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_dec.regwrite   = 1'b1;
        ctrl_dec.alusrc     = 1'b1;
        ctrl_dec.alucontrol = ALU_ADD;
      end
      OP_J:    jump_dec = 1'b1;
      default: ill_dec  = 1'b1;
    endcase
    if (ill_dec) ctrl_dec = '0;
    wr_dec = ill_dec ? '0 : (ctrl_dec.regdst ? rd_d : rt_d);
  end

  assign illegal_d = ill_dec;

  // hazard resolution: taken branch beats stall, stall beats jump
  always_comb begin
    if (FWD_EN)
      haz = de_q.c.memtoreg & hit(de_q.wr, rs_d, rt_d);
    else
      haz = (de_q.c.regwrite & hit(de_q.wr, rs_d, rt_d)) |
            (em_q.regwrite   & hit(em_q.wr, rs_d, rt_d));
    pcsrc_e = de_q.c.branch & zero_e;
    stall_d = haz & ~pcsrc_e;
    stall_f = stall_d;
    flush_e = pcsrc_e | haz;
    jump_d  = jump_dec & ~haz & ~pcsrc_e;
    flush_d = pcsrc_e | jump_d;
  end

  // forwarding selects for the two ALU operands in E
  always_comb begin
    fwd_a_e = fwd_sel(de_q.rs, em_q, mw_q);
    fwd_b_e = fwd_sel(de_q.rt, em_q, mw_q);
  end

  // next-state of the pipeline registers; a flushed D/E slot becomes all-zero
  always_comb begin
    de_d = flush_e ? '0 : '{c: ctrl_dec, rs: rs_d, rt: rt_d, wr: wr_dec};
    em_d = '{regwrite: de_q.c.regwrite, memtoreg: de_q.c.memtoreg,
             memwrite: de_q.c.memwrite, wr: de_q.wr};
    mw_d = '{regwrite: em_q.regwrite, memtoreg: em_q.memtoreg, wr: em_q.wr};
  end

  // D/E, E/M, M/W registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_d && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flush_d || flush_e) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign alusrc_e     = de_q.c.alusrc;
  assign alucontrol_e = de_q.c.alucontrol;
  assign regdst_e     = de_q.c.regdst;
  assign memwrite_m   = em_q.memwrite;
  assign regwrite_w   = mw_q.regwrite;
  assign memtoreg_w   = mw_q.memtoreg;
  assign writereg_w   = mw_q.wr;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: three instances (forwarding, no forwarding,
// 2-bit counters) share one instruction-level reference model; only the
// selected instance receives stimulus, the others see zero inputs.
module tb_pipeline_controller;

  localparam logic [31:0] NOP = 32'h0000_0020;  // add $0,$0,$0

  logic clk, rst_n;
  int   sel;
  logic [5:0] op_i, fn_i;
  logic [4:0] rs_i, rt_i, rd_i;
  logic       z_i;

  logic [5:0] opc[3], fnc[3];
  logic [4:0] rsv[3], rtv[3], rdv[3];
  logic       zv[3];

  logic       jd[3], pcs_o[3], asrc_o[3], mw_o[3], rw_o[3], mtr_o[3], rdst_o[3];
  logic [2:0] aluc_o[3];
  logic [4:0] wr_o[3];
  logic [1:0] fa_o[3], fb_o[3];
  logic       sf_o[3], sd_o[3], fd_o[3], fe_o[3], il_o[3];
  logic [15:0] sc[3], fc[3];
  logic [1:0]  sc2, fc2;

  for (genvar k = 0; k < 3; k++) begin : g_in
    assign opc[k] = (sel == k) ? op_i : 6'd0;
    assign fnc[k] = (sel == k) ? fn_i : 6'd0;
    assign rsv[k] = (sel == k) ? rs_i : 5'd0;
    assign rtv[k] = (sel == k) ? rt_i : 5'd0;
    assign rdv[k] = (sel == k) ? rd_i : 5'd0;
    assign zv[k]  = (sel == k) ? z_i  : 1'b0;
  end
  assign sc[2] = {14'd0, sc2};
  assign fc[2] = {14'd0, fc2};

  pipeline_controller #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .reset(rst_n), .opcode_d(opc[0]), .funct_d(fnc[0]), .rs_d(rsv[0]),
    .rt_d(rtv[0]), .rd_d(rdv[0]), .zero_e(zv[0]), .jump_d(jd[0]), .pcsrc_e(pcs_o[0]),
    .alusrc_e(asrc_o[0]), .alucontrol_e(aluc_o[0]), .memwrite_m(mw_o[0]),
    .regwrite_w(rw_o[0]), .memtoreg_w(mtr_o[0]), .writereg_w(wr_o[0]), .regdst_e(rdst_o[0]),
    .fwd_a_e(fa_o[0]), .fwd_b_e(fb_o[0]), .stall_f(sf_o[0]), .stall_d(sd_o[0]),
    .flush_d(fd_o[0]), .flush_e(fe_o[0]), .illegal_d(il_o[0]),
    .stall_cnt(sc[0]), .flush_cnt(fc[0]));

  pipeline_controller #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .reset(rst_n), .opcode_d(opc[1]), .funct_d(fnc[1]), .rs_d(rsv[1]),
    .rt_d(rtv[1]), .rd_d(rdv[1]), .zero_e(zv[1]), .jump_d(jd[1]), .pcsrc_e(pcs_o[1]),
    .alusrc_e(asrc_o[1]), .alucontrol_e(aluc_o[1]), .memwrite_m(mw_o[1]),
    .regwrite_w(rw_o[1]), .memtoreg_w(mtr_o[1]), .writereg_w(wr_o[1]), .regdst_e(rdst_o[1]),
    .fwd_a_e(fa_o[1]), .fwd_b_e(fb_o[1]), .stall_f(sf_o[1]), .stall_d(sd_o[1]),
    .flush_d(fd_o[1]), .flush_e(fe_o[1]), .illegal_d(il_o[1]),
    .stall_cnt(sc[1]), .flush_cnt(fc[1]));

  pipeline_controller #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .reset(rst_n), .opcode_d(opc[2]), .funct_d(fnc[2]), .rs_d(rsv[2]),
    .rt_d(rtv[2]), .rd_d(rdv[2]), .zero_e(zv[2]), .jump_d(jd[2]), .pcsrc_e(pcs_o[2]),
    .alusrc_e(asrc_o[2]), .alucontrol_e(aluc_o[2]), .memwrite_m(mw_o[2]),
    .regwrite_w(rw_o[2]), .memtoreg_w(mtr_o[2]), .writereg_w(wr_o[2]), .regdst_e(rdst_o[2]),
    .fwd_a_e(fa_o[2]), .fwd_b_e(fb_o[2]), .stall_f(sf_o[2]), .stall_d(sd_o[2]),
    .flush_d(fd_o[2]), .flush_e(fe_o[2]), .illegal_d(il_o[2]),
    .stall_cnt(sc2), .flush_cnt(fc2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (instruction records per stage) ----------
  typedef struct packed {
    logic rw, mtr, mw, br, jmp, asrc, rdst, ill;
    logic [2:0] alu;
    logic [4:0] rs, rt, wr;
  } ins_t;

  ins_t mE, mM, mW, md;
  logic hz, pcs, stl, fle, fld, jmp;
  logic [1:0] fa, fb;
  int unsigned esc, efc, mcmax;
  bit mfwd;
  int zmode;
  logic [31:0] cur;
  logic [31:0] pq[$];
  int n_err, n_chk;

  function automatic ins_t dec(input logic [31:0] w);
    ins_t r;
    r = '0;
    r.rs = w[25:21];
    r.rt = w[20:16];
    case (w[31:26])
      6'h00: begin
        r.rw = 1'b1; r.rdst = 1'b1;
        case (w[5:0])
          6'h20: r.alu = 3'd2;
          6'h22: r.alu = 3'd6;
          6'h24: r.alu = 3'd0;
          6'h25: r.alu = 3'd1;
          6'h2a: r.alu = 3'd7;
          default: r.ill = 1'b1;
        endcase
      end
      6'h23: begin r.rw = 1'b1; r.mtr = 1'b1; r.asrc = 1'b1; r.alu = 3'd2; end
      6'h2b: begin r.mw = 1'b1; r.asrc = 1'b1; r.alu = 3'd2; end
      6'h04: begin r.br = 1'b1; r.alu = 3'd6; end
      6'h08: begin r.rw = 1'b1; r.asrc = 1'b1; r.alu = 3'd2; end
      6'h02: r.jmp = 1'b1;
      default: r.ill = 1'b1;
    endcase
    if (r.ill) begin r.rw = 1'b0; r.rdst = 1'b0; r.alu = 3'd0; r.wr = 5'd0; end
    else       r.wr = r.rdst ? w[15:11] : w[20:16];
    return r;
  endfunction

  function automatic logic reads(input logic [4:0] w, input ins_t d);
    return (w != 5'd0) && ((w == d.rs) || (w == d.rt));
  endfunction

  function automatic logic [1:0] src_of(input logic [4:0] r);
    if (!mfwd || r == 5'd0)     return 2'b00;
    if (mM.rw && mM.wr == r)    return 2'b10;
    if (mW.rw && mW.wr == r)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    mE = '0; mM = '0; mW = '0; esc = 0; efc = 0;
  endtask

  task automatic model_comb();
    md  = dec(cur);
    pcs = mE.br & z_i;
    if (mfwd) hz = mE.mtr && reads(mE.wr, md);
    else      hz = (mE.rw && reads(mE.wr, md)) || (mM.rw && reads(mM.wr, md));
    stl = hz && !pcs;
    fle = pcs || hz;
    jmp = md.jmp && !hz && !pcs;
    fld = pcs || jmp;
    fa  = src_of(mE.rs);
    fb  = src_of(mE.rt);
  endtask

  task automatic model_seq();
    if (stl && esc < mcmax) esc++;
    if ((fld || fle) && efc < mcmax) efc++;
    mW = mM;
    mM = mE;
    mE = fle ? '0 : md;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h t=%0t", tag, sel, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("jump_d",       32'(jd[sel]),     32'(jmp));
    chk("pcsrc_e",      32'(pcs_o[sel]),  32'(pcs));
    chk("alusrc_e",     32'(asrc_o[sel]), 32'(mE.asrc));
    chk("alucontrol_e", 32'(aluc_o[sel]), 32'(mE.alu));
    chk("regdst_e",     32'(rdst_o[sel]), 32'(mE.rdst));
    chk("memwrite_m",   32'(mw_o[sel]),   32'(mM.mw));
    chk("regwrite_w",   32'(rw_o[sel]),   32'(mW.rw));
    chk("memtoreg_w",   32'(mtr_o[sel]),  32'(mW.mtr));
    chk("writereg_w",   32'(wr_o[sel]),   32'(mW.wr));
    chk("fwd_a_e",      32'(fa_o[sel]),   32'(fa));
    chk("fwd_b_e",      32'(fb_o[sel]),   32'(fb));
    chk("stall_f",      32'(sf_o[sel]),   32'(stl));
    chk("stall_d",      32'(sd_o[sel]),   32'(stl));
    chk("flush_d",      32'(fd_o[sel]),   32'(fld));
    chk("flush_e",      32'(fe_o[sel]),   32'(fle));
    chk("illegal_d",    32'(il_o[sel]),   32'(md.ill));
    chk("stall_cnt",    32'(sc[sel]),     esc);
    chk("flush_cnt",    32'(fc[sel]),     efc);
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] rw_(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] iw_(input logic [5:0] op, input int rt, input int rs);
    return {op, 5'(rs), 5'(rt), 16'd0};
  endfunction

  function automatic logic [31:0] rnd_ins();
    int k;
    int a, b, c;
    k = int'($urandom_range(0, 15));
    a = int'($urandom_range(0, 3));
    b = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    case (k)
      0:       return rw_(6'h20, c, a, b);
      1:       return rw_(6'h22, c, a, b);
      2:       return rw_(6'h24, c, a, b);
      3:       return rw_(6'h25, c, a, b);
      4:       return rw_(6'h2a, c, a, b);
      5, 6:    return iw_(6'h23, b, a);
      7:       return iw_(6'h2b, b, a);
      8, 9:    return iw_(6'h04, b, a);
      10:      return iw_(6'h08, b, a);
      11:      return {6'h02, 5'(a), 5'(b), 16'd0};
      12:      return rw_(6'h3f, c, a, b);
      13:      return iw_(6'h3f, b, a);
      default: return rw_(6'h20, c, a, b);
    endcase
  endfunction

  task automatic drive();
    op_i = cur[31:26];
    fn_i = cur[5:0];
    rs_i = cur[25:21];
    rt_i = cur[20:16];
    rd_i = cur[15:11];
    z_i  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
  endtask

  // one clock: check at negedge, advance model at posedge, then fetch
  task automatic cycle();
    @(negedge clk);
    model_comb();
    check_all();
    @(posedge clk);
    model_seq();
    if (!stl) begin
      if (fld)                cur = 32'd0;
      else if (pq.size() > 0) cur = pq.pop_front();
      else                    cur = NOP;
    end
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // called just after a posedge; checks that reset clears state before any edge
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    pq.delete();
    cur = NOP;
    drive();
    #1;
    model_comb();
    check_all();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic start();
    cur = pq.pop_front();
    drive();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_err = 0; n_chk = 0;
    rst_n = 1'b1; sel = 0; zmode = 0; mfwd = 1'b1; mcmax = 65535;
    cur = NOP; drive(); model_reset();
    @(posedge clk); #1;
    do_reset();

    // add $3,$1,$2 ; sub $4,$3,$1 -> M forward, no stall
    pq.push_back(rw_(6'h20, 3, 1, 2));
    pq.push_back(rw_(6'h22, 4, 3, 1));
    start(); run(6);
    chk("fwd_nostall_cnt", 32'(sc[sel]), 32'd0);

    // lw $5 ; add $6,$5,$5 -> one bubble then W forward
    do_reset();
    pq.push_back(iw_(6'h23, 5, 0));
    pq.push_back(rw_(6'h20, 6, 5, 5));
    start(); run(7);
    chk("loaduse_cnt", 32'(sc[sel]), 32'd1);

    // beq $1,$1 taken; shadow add $7 squashed, then target add $8
    do_reset();
    zmode = 1;
    pq.push_back(iw_(6'h04, 1, 1));
    pq.push_back(rw_(6'h20, 7, 1, 2));
    pq.push_back(rw_(6'h20, 8, 1, 2));
    start(); run(8);
    chk("branch_flush_cnt", 32'(fc[sel]), 32'd1);
    zmode = 0;

    // j whose fields alias the load target -> held, then jump + flush
    do_reset();
    pq.push_back(iw_(6'h23, 5, 0));
    pq.push_back({6'h02, 5'd5, 21'd0});
    pq.push_back(rw_(6'h20, 9, 1, 2));
    start(); run(8);
    chk("jump_stall_cnt", 32'(sc[sel]), 32'd1);
    chk("jump_flush_cnt", 32'(fc[sel]), 32'd2);

    // illegal opcode becomes a bubble
    do_reset();
    pq.push_back({6'h3f, 5'd1, 5'd2, 5'd3, 11'd0});
    start(); run(6);

    // random stream, then an asynchronous reset mid-stream
    do_reset();
    zmode = 2;
    for (int i = 0; i < 300; i++) pq.push_back(rnd_ins());
    start(); run(300);
    do_reset();
    zmode = 0;

    // no-forwarding instance
    sel = 1; mfwd = 1'b0;
    @(posedge clk); #1;
    do_reset();
    pq.push_back(rw_(6'h20, 3, 1, 2));
    pq.push_back(rw_(6'h20, 4, 3, 3));
    start(); run(8);
    chk("nofwd_stall_cnt", 32'(sc[sel]), 32'd2);

    // taken branch in E while D waits on a load in M -> flush wins
    do_reset();
    zmode = 1;
    pq.push_back(iw_(6'h23, 5, 0));
    pq.push_back(iw_(6'h04, 1, 1));
    pq.push_back(rw_(6'h20, 6, 5, 5));
    pq.push_back(rw_(6'h20, 8, 1, 2));
    start(); run(8);
    chk("flush_beats_stall_cnt", 32'(sc[sel]), 32'd0);

    do_reset();
    zmode = 2;
    for (int i = 0; i < 200; i++) pq.push_back(rnd_ins());
    start(); run(200);
    zmode = 0;

    // 2-bit counter instance: five load-use stalls saturate at 3
    sel = 2; mfwd = 1'b1; mcmax = 3;
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pq.push_back(iw_(6'h23, 5, 0));
      pq.push_back(rw_(6'h20, 6, 5, 5));
    end
    start(); run(20);
    chk("sat_stall_cnt", 32'(sc[sel]), 32'd3);

    do_reset();
    zmode = 2;
    for (int i = 0; i < 100; i++) pq.push_back(rnd_ins());
    start(); run(100);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
